// File: rtl/ex_mem_stage_pkg.sv
// Shared types and constants for the MIPS execute stage (package ex_pkg).
// Control field layouts: ex={RegDst,ALUOp[1:0],ALUSrc}, m={Branch,MemRead,MemWrite}, wb={RegWrite,MemtoReg}.
package ex_pkg;
  localparam int XLEN = 32;
  localparam int RIDX = 5;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ADD_B = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU_NOP marks an undecodable funct; the ALU then produces 0.
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOP = 4'b1111
  } aluctl_e;

  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef struct packed {
    logic [1:0]      wb;
    logic            branch;
    logic            memread;
    logic            memwrite;
    logic [XLEN-1:0] add_result;
    logic            zero;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rdata2;
    logic [RIDX-1:0] dst;
  } exmem_t;

  // Operand forwarding: EX/MEM beats MEM/WB; register 0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_pick(
    input logic [RIDX-1:0] idx,   input logic [XLEN-1:0] rf,
    input logic            exw,   input logic [RIDX-1:0] exrd, input logic [XLEN-1:0] exd,
    input logic            mww,   input logic [RIDX-1:0] mwrd, input logic [XLEN-1:0] mwd);
    if (exw && exrd != '0 && exrd == idx)      return exd;
    else if (mww && mwrd != '0 && mwrd == idx) return mwd;
    else                                       return rf;
  endfunction
endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX bundle in, EX/MEM register out. Forwarding sources exist only with EX_FWD_EN.
interface ex_mem_stage_if #(parameter int DATA_W = 32, parameter int REG_AW = 5);
  logic [1:0]        wb_ctl;
  logic [2:0]        m_ctl;
  logic [3:0]        ex_ctl;
  logic [DATA_W-1:0] npc, rdata1, rdata2, s_extend;
  logic [REG_AW-1:0] instr_2016, instr_1511;
  logic              stall, flush;
  logic [1:0]        wb_ctlout;
  logic              branch, memread, memwrite, zero;
  logic [DATA_W-1:0] add_result, alu_result, rdata2out;
  logic [REG_AW-1:0] five_bit_muxout;
`ifdef EX_FWD_EN
  logic [REG_AW-1:0] instr_2521, exmem_rd, memwb_rd;
  logic              exmem_regwrite, memwb_regwrite;
  logic [DATA_W-1:0] exmem_data, memwb_data;
`endif

  modport slave (
`ifdef EX_FWD_EN
    input  instr_2521, exmem_regwrite, exmem_rd, exmem_data, memwb_regwrite, memwb_rd, memwb_data,
`endif
    input  wb_ctl, m_ctl, ex_ctl, npc, rdata1, rdata2, s_extend, instr_2016, instr_1511, stall, flush,
    output wb_ctlout, branch, memread, memwrite, add_result, zero, alu_result, rdata2out, five_bit_muxout
  );

  modport master (
`ifdef EX_FWD_EN
    output instr_2521, exmem_regwrite, exmem_rd, exmem_data, memwb_regwrite, memwb_rd, memwb_data,
`endif
    output wb_ctl, m_ctl, ex_ctl, npc, rdata1, rdata2, s_extend, instr_2016, instr_1511, stall, flush,
    input  wb_ctlout, branch, memread, memwrite, add_result, zero, alu_result, rdata2out, five_bit_muxout
  );
endinterface

// File: rtl/ex_mem_stage_alu.sv
// ALU control decode and 32-bit ALU (combinational).
module ex_alu
  import ex_pkg::*;
(
  input  logic [1:0]      aluop,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  aluctl_e w_ctl;

  always_comb begin
    w_ctl = ALU_NOP;
    case (aluop)
      ALUOP_ADD, ALUOP_ADD_B: w_ctl = ALU_ADD;
      ALUOP_SUB:              w_ctl = ALU_SUB;
      default: begin
        case (funct)
          FUNCT_ADD: w_ctl = ALU_ADD;
          FUNCT_SUB: w_ctl = ALU_SUB;
          FUNCT_AND: w_ctl = ALU_AND;
          FUNCT_OR:  w_ctl = ALU_OR;
          FUNCT_SLT: w_ctl = ALU_SLT;
          default:   w_ctl = ALU_NOP;
        endcase
      end
    endcase
  end

  always_comb begin
    result = '0;
    case (w_ctl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/ex_mem_stage.sv
// MIPS execute stage with EX/MEM pipeline register. Optional forwarding: define EX_FWD_EN.
// Register priority per edge: reset > flush > stall > load.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic             clk,
  input logic             reset,
  ex_mem_stage_if.slave   bus
);
  logic [DATA_W-1:0] w_a, w_rt, w_b, w_alu, w_tgt;
  logic              w_zero;
  logic [REG_AW-1:0] w_dst;
  exmem_t            w_d, r_q;

`ifdef EX_FWD_EN
  assign w_a  = fwd_pick(bus.instr_2521, bus.rdata1, bus.exmem_regwrite, bus.exmem_rd, bus.exmem_data,
                         bus.memwb_regwrite, bus.memwb_rd, bus.memwb_data);
  assign w_rt = fwd_pick(bus.instr_2016, bus.rdata2, bus.exmem_regwrite, bus.exmem_rd, bus.exmem_data,
                         bus.memwb_regwrite, bus.memwb_rd, bus.memwb_data);
`else
  assign w_a  = bus.rdata1;
  assign w_rt = bus.rdata2;
`endif

  assign w_b   = bus.ex_ctl[EX_ALUSRC] ? bus.s_extend : w_rt;
  assign w_dst = bus.ex_ctl[EX_REGDST] ? bus.instr_1511 : bus.instr_2016;
  // Word offset: the top two immediate bits fall off, wrapping modulo 2^32.
  assign w_tgt = bus.npc + {bus.s_extend[DATA_W-3:0], 2'b00};

  ex_alu u_alu (
    .aluop  (bus.ex_ctl[EX_ALUOP_HI:EX_ALUOP_LO]),
    .funct  (bus.s_extend[5:0]),
    .a      (w_a),
    .b      (w_b),
    .result (w_alu),
    .zero   (w_zero)
  );

  always_comb begin
    w_d            = '0;
    w_d.wb         = bus.wb_ctl;
    w_d.branch     = bus.m_ctl[M_BRANCH];
    w_d.memread    = bus.m_ctl[M_MEMREAD];
    w_d.memwrite   = bus.m_ctl[M_MEMWRITE];
    w_d.add_result = w_tgt;
    w_d.zero       = w_zero;
    w_d.alu_result = w_alu;
    w_d.rdata2     = w_rt;
    w_d.dst        = w_dst;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_q <= '0;
    else if (bus.flush)  r_q <= '0;
    else if (!bus.stall) r_q <= w_d;
  end

  assign bus.wb_ctlout       = r_q.wb;
  assign bus.branch          = r_q.branch;
  assign bus.memread         = r_q.memread;
  assign bus.memwrite        = r_q.memwrite;
  assign bus.add_result      = r_q.add_result;
  assign bus.zero            = r_q.zero;
  assign bus.alu_result      = r_q.alu_result;
  assign bus.rdata2out       = r_q.rdata2;
  assign bus.five_bit_muxout = r_q.dst;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed table, pipeline-control sequences, random run vs reference model.
module tb_ex_mem_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_mem_stage_if u_if ();
  ex_mem_stage u_dut (.clk(clk), .reset(reset), .bus(u_if));

  typedef struct {
    logic [1:0] wb; logic [2:0] m; logic [3:0] ex;
    logic [31:0] npc, r1, r2, sx; logic [4:0] rt, rd;
    logic [31:0] e_alu; logic e_z; logic [4:0] e_dst; logic [31:0] e_add;
  } vec_t;

  typedef struct packed {
    logic [1:0] wb; logic br, mr, mw; logic [31:0] add; logic z;
    logic [31:0] alu, sd; logic [4:0] dst;
  } out_t;

  function automatic vec_t mk(logic [1:0] wb, logic [2:0] m, logic [3:0] ex, logic [31:0] npc,
                              logic [31:0] r1, logic [31:0] r2, logic [31:0] sx,
                              logic [31:0] e_alu, logic e_z, logic use_rd, logic [31:0] e_add);
    vec_t v;
    v.wb = wb; v.m = m; v.ex = ex; v.npc = npc; v.r1 = r1; v.r2 = r2; v.sx = sx;
    v.rt = 5'd2; v.rd = 5'd9;
    v.e_alu = e_alu; v.e_z = e_z; v.e_dst = use_rd ? 5'd9 : 5'd2; v.e_add = e_add;
    return v;
  endfunction

  function automatic out_t vec_exp(vec_t v);
    out_t o;
    o.wb = v.wb; o.br = v.m[2]; o.mr = v.m[1]; o.mw = v.m[0];
    o.add = v.e_add; o.z = v.e_z; o.alu = v.e_alu; o.sd = v.r2; o.dst = v.e_dst;
    return o;
  endfunction

  task automatic drive(vec_t v);
    u_if.wb_ctl = v.wb; u_if.m_ctl = v.m; u_if.ex_ctl = v.ex; u_if.npc = v.npc;
    u_if.rdata1 = v.r1; u_if.rdata2 = v.r2; u_if.s_extend = v.sx;
    u_if.instr_2016 = v.rt; u_if.instr_1511 = v.rd;
  endtask

  task automatic chk1(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, out_t e);
    chk1({nm, ".wb"},  {30'd0, u_if.wb_ctlout}, {30'd0, e.wb});
    chk1({nm, ".m"},   {29'd0, u_if.branch, u_if.memread, u_if.memwrite}, {29'd0, e.br, e.mr, e.mw});
    chk1({nm, ".add"}, u_if.add_result, e.add);
    chk1({nm, ".z"},   {31'd0, u_if.zero}, {31'd0, e.z});
    chk1({nm, ".alu"}, u_if.alu_result, e.alu);
    chk1({nm, ".sd"},  u_if.rdata2out, e.sd);
    chk1({nm, ".dst"}, {27'd0, u_if.five_bit_muxout}, {27'd0, e.dst});
  endtask

  // Reference: evaluate one instruction straight from the ISA rules.
  function automatic out_t model(logic [1:0] wb, logic [2:0] m, logic [3:0] ex, logic [31:0] npc,
                                 logic [31:0] a, logic [31:0] rtv, logic [31:0] sx,
                                 logic [4:0] rt, logic [4:0] rd);
    out_t o;
    logic [31:0] b, r;
    b = ex[0] ? sx : rtv;
    r = 32'd0;
    if (ex[2:1] == 2'd1) r = a - b;
    else if (ex[2:1] != 2'd2) r = a + b;
    else if (sx[5:0] == 6'd32) r = a + b;
    else if (sx[5:0] == 6'd34) r = a - b;
    else if (sx[5:0] == 6'd36) r = a & b;
    else if (sx[5:0] == 6'd37) r = a | b;
    else if (sx[5:0] == 6'd42) r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    o.wb = wb; o.br = m[2]; o.mr = m[1]; o.mw = m[0];
    o.add = npc + sx * 4; o.z = (r == 0); o.alu = r; o.sd = rtv; o.dst = ex[3] ? rd : rt;
    return o;
  endfunction

  function automatic logic [31:0] ref_fwd(logic [4:0] idx, logic [31:0] rf, logic ew, logic [4:0] er,
                                          logic [31:0] ed, logic mw, logic [4:0] mr, logic [31:0] md);
    logic [31:0] v;
    v = rf;
    if (mw && mr == idx && idx != 0) v = md;
    if (ew && er == idx && idx != 0) v = ed;
    return v;
  endfunction

  vec_t vt[11];
  out_t exp_q, nxt;

  initial begin
    vt[0]  = mk(2'b10, 3'b000, 4'b1100, 32'h0,   32'd5,        32'd7,        32'h20,       32'd12,    1'b0, 1'b1, 32'h80);
    vt[1]  = mk(2'b00, 3'b100, 4'b0010, 32'h100, 32'h1234,     32'h1234,     32'hFFFFFFFE, 32'd0,     1'b1, 1'b0, 32'hF8);
    vt[2]  = mk(2'b10, 3'b000, 4'b1100, 32'h0,   32'hFFFFFFFF, 32'd1,        32'h2A,       32'd1,     1'b0, 1'b1, 32'hA8);
    vt[3]  = mk(2'b10, 3'b000, 4'b1100, 32'h0,   32'd1,        32'hFFFFFFFF, 32'h2A,       32'd0,     1'b1, 1'b1, 32'hA8);
    vt[4]  = mk(2'b11, 3'b010, 4'b0001, 32'h40,  32'h1000,     32'hDEAD,     32'hFFFFFFFC, 32'hFFC,   1'b0, 1'b0, 32'h30);
    vt[5]  = mk(2'b10, 3'b000, 4'b1100, 32'h0,   32'd10,       32'd3,        32'h22,       32'd7,     1'b0, 1'b1, 32'h88);
    vt[6]  = mk(2'b10, 3'b000, 4'b1100, 32'h0,   32'hF0F0,     32'hFF00,     32'h24,       32'hF000,  1'b0, 1'b1, 32'h90);
    vt[7]  = mk(2'b10, 3'b000, 4'b1100, 32'h0,   32'hF0F0,     32'hFF00,     32'h25,       32'hFFF0,  1'b0, 1'b1, 32'h94);
    vt[8]  = mk(2'b10, 3'b000, 4'b1100, 32'h0,   32'd5,        32'd5,        32'h3F,       32'd0,     1'b1, 1'b1, 32'hFC);
    vt[9]  = mk(2'b10, 3'b000, 4'b1110, 32'h0,   32'hFFFFFFFF, 32'd1,        32'h3F,       32'd0,     1'b1, 1'b1, 32'hFC);
    vt[10] = mk(2'b00, 3'b001, 4'b0001, 32'h0,   32'h20,       32'h55,       32'd4,        32'h24,    1'b0, 1'b0, 32'h10);

    u_if.stall = 1'b0; u_if.flush = 1'b0;
    drive(vt[0]);
`ifdef EX_FWD_EN
    u_if.instr_2521 = 5'd1; u_if.exmem_regwrite = 1'b0; u_if.exmem_rd = 5'd0; u_if.exmem_data = '0;
    u_if.memwb_regwrite = 1'b0; u_if.memwb_rd = 5'd0; u_if.memwb_data = '0;
`endif
    @(posedge clk); #1;
    chk_out("reset", '0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vt[i]);
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", i), vec_exp(vt[i]));
    end

    // Stall holds across two edges while inputs move, then flush overrides stall.
    drive(vt[0]); @(posedge clk); #1;
    u_if.stall = 1'b1; drive(vt[1]); @(posedge clk); #1;
    chk_out("stall1", vec_exp(vt[0]));
    drive(vt[4]); @(posedge clk); #1;
    chk_out("stall2", vec_exp(vt[0]));
    u_if.flush = 1'b1; @(posedge clk); #1;
    chk_out("stall_flush", '0);
    u_if.flush = 1'b0; u_if.stall = 1'b0;

    // Asynchronous reset between edges.
    drive(vt[4]); @(posedge clk); #1;
    chk_out("pre_rst", vec_exp(vt[4]));
    #2 reset = 1'b1; #1;
    chk_out("async_rst", '0);
    reset = 1'b0;

`ifdef EX_FWD_EN
    drive(mk(2'b10, 3'b000, 4'b1100, 32'h0, 32'd100, 32'd0, 32'h20, 32'd9, 1'b0, 1'b1, 32'h80));
    u_if.instr_2521 = 5'd3; u_if.exmem_regwrite = 1'b1; u_if.exmem_rd = 5'd3; u_if.exmem_data = 32'd9;
    u_if.memwb_regwrite = 1'b1; u_if.memwb_rd = 5'd3; u_if.memwb_data = 32'd4;
    @(posedge clk); #1;
    chk1("fwd_exmem", u_if.alu_result, 32'd9);
    u_if.instr_2521 = 5'd0; u_if.exmem_rd = 5'd0; u_if.memwb_rd = 5'd0;
    @(posedge clk); #1;
    chk1("fwd_r0", u_if.alu_result, 32'd100);
`endif

    // Random run; the model keeps its own copy of the EX/MEM contents.
    @(posedge clk); #1;
    exp_q = model(u_if.wb_ctl, u_if.m_ctl, u_if.ex_ctl, u_if.npc, u_if.rdata1, u_if.rdata2,
                  u_if.s_extend, u_if.instr_2016, u_if.instr_1511);
`ifdef EX_FWD_EN
    exp_q.alu = u_if.rdata1 + u_if.rdata2; exp_q.z = (exp_q.alu == 0);
`endif
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, rtv;
      logic [5:0]  fl[6];
      fl[0] = 6'd32; fl[1] = 6'd34; fl[2] = 6'd36; fl[3] = 6'd37; fl[4] = 6'd42; fl[5] = 6'($urandom);
      u_if.wb_ctl = 2'($urandom); u_if.m_ctl = 3'($urandom); u_if.ex_ctl = 4'($urandom);
      u_if.npc = $urandom; u_if.rdata1 = ($urandom % 2) ? $urandom : $urandom_range(0, 4);
      u_if.rdata2 = ($urandom % 4 == 0) ? u_if.rdata1 : $urandom;
      u_if.s_extend = {$urandom} & 32'hFFFFFFC0 | {26'd0, fl[$urandom_range(0, 5)]};
      u_if.instr_2016 = 5'($urandom_range(0, 3)); u_if.instr_1511 = 5'($urandom);
      u_if.stall = ($urandom % 5 == 0); u_if.flush = ($urandom % 8 == 0);
      a = u_if.rdata1; rtv = u_if.rdata2;
`ifdef EX_FWD_EN
      u_if.instr_2521 = 5'($urandom_range(0, 3));
      u_if.exmem_regwrite = 1'($urandom); u_if.exmem_rd = 5'($urandom_range(0, 3)); u_if.exmem_data = $urandom;
      u_if.memwb_regwrite = 1'($urandom); u_if.memwb_rd = 5'($urandom_range(0, 3)); u_if.memwb_data = $urandom;
      a   = ref_fwd(u_if.instr_2521, u_if.rdata1, u_if.exmem_regwrite, u_if.exmem_rd, u_if.exmem_data,
                    u_if.memwb_regwrite, u_if.memwb_rd, u_if.memwb_data);
      rtv = ref_fwd(u_if.instr_2016, u_if.rdata2, u_if.exmem_regwrite, u_if.exmem_rd, u_if.exmem_data,
                    u_if.memwb_regwrite, u_if.memwb_rd, u_if.memwb_data);
`endif
      if (u_if.flush) nxt = '0;
      else if (u_if.stall) nxt = exp_q;
      else nxt = model(u_if.wb_ctl, u_if.m_ctl, u_if.ex_ctl, u_if.npc, a, rtv,
                       u_if.s_extend, u_if.instr_2016, u_if.instr_1511);
      @(posedge clk); #1;
      exp_q = nxt;
      chk_out($sformatf("rnd%0d", i), exp_q);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
